// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 16-input mux round-robin arbiter.
package mux_arb_pkg;

  localparam int ARB_NUM_REQ          = 16;
  localparam int ARB_SEL_WIDTH        = 4;
  localparam int ARB_MAX_HOLD_DEFAULT = 8;
  localparam int ARB_HOLD_W           = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin search: first set request at or above ptr_i, wrapping 15 -> 0.
module rr_pick16
  import mux_arb_pkg::*;
(
  input  logic [ARB_NUM_REQ-1:0]   req_i,
  input  logic [ARB_SEL_WIDTH-1:0] ptr_i,
  output logic [ARB_NUM_REQ-1:0]   win_o,
  output logic [ARB_SEL_WIDTH-1:0] idx_o,
  output logic                     vld_o
);

  logic [ARB_SEL_WIDTH-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
  always_comb begin
    win_o = '0;
    idx_o = ptr_i;
    vld_o = 1'b0;
    cand  = ptr_i;
    for (int i = ARB_NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr_i + ARB_SEL_WIDTH'(i);
      if (req_i[cand]) begin
        idx_o = cand;
        vld_o = 1'b1;
      end
    end
    if (vld_o) begin
      win_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/mux_16x1_rr_arbiter.sv
// Round-robin grant scheduler driving mux_16x1.sel; holds each grant until done.
// Optional hold timeout compiled in with `define MUX_ARB_TIMEOUT_EN.
module mux_16x1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int NUM_REQ   = ARB_NUM_REQ,
  parameter int SEL_WIDTH = ARB_SEL_WIDTH,
  parameter int MAX_HOLD  = ARB_MAX_HOLD_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic                 done,
  input  logic                 mux_out,
  output logic [NUM_REQ-1:0]   grant,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 grant_valid,
  output logic                 data_q,
  output logic                 timeout
);

  if (NUM_REQ != ARB_NUM_REQ || SEL_WIDTH != ARB_SEL_WIDTH ||
      MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_params
    $error("mux_16x1_rr_arbiter: unsupported parameter combination");
  end

  arb_state_e           state_q, state_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 capt_q, capt_d;
  logic                 expire;

  logic [NUM_REQ-1:0]   pick_win;
  logic [SEL_WIDTH-1:0] pick_idx;
  logic                 pick_vld;

  rr_pick16 u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .win_o (pick_win),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

`ifdef MUX_ARB_TIMEOUT_EN
  logic [ARB_HOLD_W-1:0] hold_q, hold_d;
  logic                  timeout_q, timeout_d;

  assign expire    = (hold_q == ARB_HOLD_W'(MAX_HOLD - 1));
  assign hold_d    = (state_q == ARB_BUSY) ? hold_q + ARB_HOLD_W'(1) : '0;
  // A coincident done is an ordinary release, so no timeout pulse.
  assign timeout_d = (state_q == ARB_BUSY) && expire && !done;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    capt_d  = capt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          state_d = ARB_BUSY;
          grant_d = pick_win;
          sel_d   = pick_idx;
        end
      end
      ARB_BUSY: begin
        if (done || expire) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          ptr_d   = sel_q + 1'b1;
          capt_d  = mux_out;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      capt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      capt_q  <= capt_d;
    end
  end

  assign grant       = grant_q;
  assign sel         = sel_q;
  assign grant_valid = (state_q == ARB_BUSY);
  assign data_q      = capt_q;

endmodule

// File: tb/tb_mux_16x1_rr_arbiter.sv
// Directed vector bench for mux_16x1_rr_arbiter, with a behavioural mux_16x1 on mux_out.
module tb_mux_16x1_rr_arbiter;

  localparam int TB_MAX_HOLD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic        mux_out;
  logic [15:0] grant;
  logic [3:0]  sel;
  logic        grant_valid;
  logic        data_q;
  logic        timeout;
  logic [15:0] mux_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign mux_out = mux_data[sel];

  mux_16x1_rr_arbiter #(
    .NUM_REQ   (16),
    .SEL_WIDTH (4),
    .MAX_HOLD  (TB_MAX_HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .mux_out     (mux_out),
    .grant       (grant),
    .sel         (sel),
    .grant_valid (grant_valid),
    .data_q      (data_q),
    .timeout     (timeout)
  );

  typedef struct {
    logic [15:0] req;
    logic        done;
    logic [15:0] g;
    logic [3:0]  s;
    logic        gv;
    logic        dq;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [15:0] r, logic d, logic [15:0] g,
                              logic [3:0] s, logic gv, logic dq);
    vec_t v;
    v.req = r; v.done = d; v.g = g; v.s = s; v.gv = gv; v.dq = dq;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [15:0] g, input logic [3:0] s,
                           input logic gv, input logic dq, input logic to);
    check({tag, ".grant"},       32'(grant),       32'(g));
    check({tag, ".sel"},         32'(sel),         32'(s));
    check({tag, ".grant_valid"}, 32'(grant_valid), 32'(gv));
    check({tag, ".data_q"},      32'(data_q),      32'(dq));
    check({tag, ".timeout"},     32'(timeout),     32'(to));
  endtask

  // Inputs change just after the edge; outputs are sampled 1 time unit after it.
  task automatic step(input logic [15:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    done     = 1'b0;
    mux_data = 16'h0022;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) tbl.push_back(mk(16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0));
    // single requester 0, released after 3 grant cycles
    tbl.push_back(mk(16'h0001, 1'b0, 16'h0001, 4'd0,  1'b1, 1'b0));
    tbl.push_back(mk(16'h0001, 1'b0, 16'h0001, 4'd0,  1'b1, 1'b0));
    tbl.push_back(mk(16'h0001, 1'b0, 16'h0001, 4'd0,  1'b1, 1'b0));
    tbl.push_back(mk(16'h0000, 1'b1, 16'h0000, 4'd0,  1'b0, 1'b0));
    // 8011 rotation from ptr=1: 4, 15, wrap to 0
    tbl.push_back(mk(16'h8011, 1'b0, 16'h0010, 4'd4,  1'b1, 1'b0));
    tbl.push_back(mk(16'h8011, 1'b1, 16'h0000, 4'd4,  1'b0, 1'b0));
    tbl.push_back(mk(16'h8011, 1'b0, 16'h8000, 4'd15, 1'b1, 1'b0));
    tbl.push_back(mk(16'h8011, 1'b1, 16'h0000, 4'd15, 1'b0, 1'b0));
    tbl.push_back(mk(16'h8011, 1'b0, 16'h0001, 4'd0,  1'b1, 1'b0));
    tbl.push_back(mk(16'h8011, 1'b1, 16'h0000, 4'd0,  1'b0, 1'b0));
    // requester 5 drops req mid-grant, mux bit 5 is 1
    tbl.push_back(mk(16'h0020, 1'b0, 16'h0020, 4'd5,  1'b1, 1'b0));
    tbl.push_back(mk(16'h0000, 1'b0, 16'h0020, 4'd5,  1'b1, 1'b0));
    tbl.push_back(mk(16'h0000, 1'b1, 16'h0000, 4'd5,  1'b0, 1'b1));
    tbl.push_back(mk(16'h0000, 1'b0, 16'h0000, 4'd5,  1'b0, 1'b1));

    foreach (tbl[i]) begin
      step(tbl[i].req, tbl[i].done);
      check_all($sformatf("vec%0d", i), tbl[i].g, tbl[i].s, tbl[i].gv, tbl[i].dq, 1'b0);
    end

    // Hold limit: ptr=6, req 0006 -> requester 1 first, then 2.
    mux_data = 16'h0000;
    step(16'h0006, 1'b0);
    check_all("hold.c1", 16'h0002, 4'd1, 1'b1, 1'b1, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      step(16'h0006, 1'b0);
      check_all($sformatf("hold.c%0d", c), 16'h0002, 4'd1, 1'b1, 1'b1, 1'b0);
    end
    step(16'h0006, 1'b0);
`ifdef MUX_ARB_TIMEOUT_EN
    check_all("hold.revoke", 16'h0000, 4'd1, 1'b0, 1'b0, 1'b1);
    step(16'h0006, 1'b0);
    check_all("hold.next", 16'h0004, 4'd2, 1'b1, 1'b0, 1'b0);
`else
    check_all("hold.kept", 16'h0002, 4'd1, 1'b1, 1'b1, 1'b0);
    step(16'h0006, 1'b1);
    check_all("hold.rel", 16'h0000, 4'd1, 1'b0, 1'b0, 1'b0);
    step(16'h0006, 1'b0);
    check_all("hold.next", 16'h0004, 4'd2, 1'b1, 1'b0, 1'b0);
`endif

    // Release requester 2 capturing a 1, then reset on the 2nd cycle of the next grant.
    mux_data = 16'h0004;
    step(16'h0000, 1'b1);
    check_all("pre_rst.rel", 16'h0000, 4'd2, 1'b0, 1'b1, 1'b0);
    step(16'h0008, 1'b0);
    check_all("pre_rst.g", 16'h0008, 4'd3, 1'b1, 1'b1, 1'b0);
    step(16'h0008, 1'b0);
    rst = 1'b1;
    step(16'h0008, 1'b0);
    check_all("rst_mid", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(16'h8011, 1'b0);
    check_all("post_rst", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b0);

    // done coinciding with the hold limit is a normal release.
    for (int c = 1; c <= 3; c++) begin
      step(16'h8011, 1'b0);
      check($sformatf("coinc.gv%0d", c), 32'(grant_valid), 32'd1);
    end
    step(16'h8011, 1'b1);
    check_all("coinc.rel", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
    step(16'h8011, 1'b0);
    check_all("coinc.next", 16'h0010, 4'd4, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
